// File: rtl/data_path.sv
// Single-bus 32-bit RISC datapath.
// Register file, special registers, bus mux, select/encode, ALU and CON.
module data_path (
    input  logic        clock,
    input  logic        clear,
    input  logic        PCout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        MDRout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        Yout,
    input  logic        InPortout,
    input  logic        Cout,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        ZHighIn,
    input  logic        ZLowIn,
    input  logic        CONin,
    input  logic        OutPortin,
    input  logic        IncPC,
    input  logic        Read,
    input  logic        Write,
    input  logic [4:0]  opcode,
    input  logic [8:0]  Address,
    input  logic [31:0] Mdatain,
    input  logic [31:0] InPortData,
    output logic [31:0] OutPortData,
    output logic        R0out,
    output logic        R1out,
    output logic        R2out,
    output logic        R3out,
    output logic        R4out,
    output logic        R5out,
    output logic        R6out,
    output logic        R7out,
    output logic        R8out,
    output logic        R9out,
    output logic        R10out,
    output logic        R11out,
    output logic        R12out,
    output logic        R13out,
    output logic        R14out,
    output logic        R15out,
    output logic        CON_out
);

    logic [31:0] r_q [16];
    logic [31:0] r_d [16];
    logic [31:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d;
    logic [31:0] mdr_q, mdr_d, y_q, y_d, hi_q, hi_d;
    logic [31:0] lo_q, lo_d, inport_q, inport_d;
    logic [31:0] outport_q, outport_d;
    logic [63:0] z_q, z_d;
    logic        con_q, con_d;

    logic [31:0] bus;
    logic [31:0] c_sext;
    logic [31:0] reg_bus;
    logic [3:0]  field;
    logic [15:0] sel;
    logic [15:0] rout_en;
    logic [15:0] rin_en;

    logic [31:0] alu_lo, alu_hi;
    logic [63:0] rot_r, rot_l, prod;
    logic [4:0]  shamt;
    logic signed [31:0] quot, rem;
    logic unused_ok;

    // Memory strobe, address and unrouted IR/MAR bits have no internal use.
    assign unused_ok = ^{Write, Address, ir_q[31:27], mar_q};

    assign field = ({4{Gra}} & ir_q[26:23])
                 | ({4{Grb}} & ir_q[22:19])
                 | ({4{Grc}} & ir_q[18:15]);
    assign sel     = 16'h0001 << field;
    assign rout_en = sel & {16{Rout | BAout}};
    assign rin_en  = sel & {16{Rin}};

    assign {R15out, R14out, R13out, R12out,
            R11out, R10out, R9out,  R8out,
            R7out,  R6out,  R5out,  R4out,
            R3out,  R2out,  R1out,  R0out} = rout_en;

    assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};

    // Register-file read port; BAout on R0 reads as zero.
    always_comb begin
        reg_bus = 32'h0;
        for (int i = 0; i < 16; i++) begin
            if (rout_en[i]) reg_bus = r_q[i];
        end
        if (BAout && rout_en[0]) reg_bus = 32'h0;
    end

    // Fixed-priority bus multiplexer.
    always_comb begin
        bus = 32'h0;
        if (|rout_en)       bus = reg_bus;
        else if (HIout)     bus = hi_q;
        else if (LOout)     bus = lo_q;
        else if (Zhighout)  bus = z_q[63:32];
        else if (Zlowout)   bus = z_q[31:0];
        else if (PCout)     bus = pc_q;
        else if (MDRout)    bus = mdr_q;
        else if (InPortout) bus = inport_q;
        else if (Cout)      bus = c_sext;
        else if (Yout)      bus = y_q;
    end

    assign shamt = bus[4:0];
    assign rot_r = {y_q, y_q} >> shamt;
    assign rot_l = {y_q, y_q} << shamt;
    assign prod  = {{32{y_q[31]}}, y_q} * {{32{bus[31]}}, bus};
    assign quot  = $signed(y_q) / $signed(bus);
    assign rem   = $signed(y_q) % $signed(bus);

    // ALU: A is Y, B is the bus; hi is only nonzero for mul/div.
    always_comb begin
        alu_lo = 32'h0;
        alu_hi = 32'h0;
        if (IncPC) begin
            alu_lo = bus + 32'd1;
        end else begin
            case (opcode)
                5'b00100: alu_lo = y_q - bus;
                5'b00101: alu_lo = y_q & bus;
                5'b00110: alu_lo = y_q | bus;
                5'b00111: alu_lo = rot_r[31:0];
                5'b01000: alu_lo = rot_l[63:32];
                5'b01001: alu_lo = y_q >> shamt;
                5'b01010: alu_lo = $signed(y_q) >>> shamt;
                5'b01011: alu_lo = y_q << shamt;
                5'b01111: begin
                    if (bus != 32'h0) begin
                        alu_lo = quot;
                        alu_hi = rem;
                    end
                end
                5'b10000: {alu_hi, alu_lo} = prod;
                5'b10001: alu_lo = 32'h0 - bus;
                5'b10010: alu_lo = ~bus;
                default:  alu_lo = y_q + bus;
            endcase
        end
    end

    // Next-state for every register from its load enable.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            r_d[i] = rin_en[i] ? bus : r_q[i];
        end
        pc_d      = PCin ? bus : pc_q;
        ir_d      = IRin ? bus : ir_q;
        mar_d     = MARin ? bus : mar_q;
        mdr_d     = MDRin ? (Read ? Mdatain : bus) : mdr_q;
        y_d       = Yin ? bus : y_q;
        hi_d      = HIin ? bus : hi_q;
        lo_d      = LOin ? bus : lo_q;
        outport_d = OutPortin ? bus : outport_q;
        inport_d  = InPortData;
        z_d       = z_q;
        if (ZHighIn) z_d[63:32] = alu_hi;
        if (ZLowIn)  z_d[31:0]  = alu_lo;
        con_d = con_q;
        if (CONin) begin
            case (ir_q[20:19])
                2'b00:   con_d = (bus == 32'h0);
                2'b01:   con_d = (bus != 32'h0);
                2'b10:   con_d = ~bus[31];
                default: con_d = bus[31];
            endcase
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) r_q[i] <= 32'h0;
            pc_q      <= 32'h0;
            ir_q      <= 32'h0;
            mar_q     <= 32'h0;
            mdr_q     <= 32'h0;
            y_q       <= 32'h0;
            hi_q      <= 32'h0;
            lo_q      <= 32'h0;
            inport_q  <= 32'h0;
            outport_q <= 32'h0;
            z_q       <= 64'h0;
            con_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            y_q       <= y_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            inport_q  <= inport_d;
            outport_q <= outport_d;
            z_q       <= z_d;
            con_q     <= con_d;
        end
    end

    assign OutPortData = outport_q;
    assign CON_out     = con_q;

endmodule

// File: tb/tb_data_path.sv
// Directed testbench for data_path.
// Each task sequences control strobes and checks ports inline.
module tb_data_path;

    logic clock, clear;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout;
    logic InPortout, Cout, Rout, BAout, Gra, Grb, Grc, Rin;
    logic PCin, IRin, MARin, MDRin, Yin, HIin, LOin;
    logic ZHighIn, ZLowIn, CONin, OutPortin, IncPC, Read, Write;
    logic [4:0]  opcode;
    logic [8:0]  Address;
    logic [31:0] Mdatain, InPortData, OutPortData;
    logic [15:0] rout;
    logic        CON_out;

    int checks = 0;
    int errors = 0;

    data_path dut (
        .clock(clock), .clear(clear),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .MDRout(MDRout), .HIout(HIout), .LOout(LOout), .Yout(Yout),
        .InPortout(InPortout), .Cout(Cout), .Rout(Rout), .BAout(BAout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .CONin(CONin),
        .OutPortin(OutPortin), .IncPC(IncPC), .Read(Read), .Write(Write),
        .opcode(opcode), .Address(Address), .Mdatain(Mdatain),
        .InPortData(InPortData), .OutPortData(OutPortData),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]),
        .R3out(rout[3]), .R4out(rout[4]), .R5out(rout[5]),
        .R6out(rout[6]), .R7out(rout[7]), .R8out(rout[8]),
        .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]),
        .R15out(rout[15]), .CON_out(CON_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout} = '0;
        {InPortout, Cout, Rout, BAout, Gra, Grb, Grc, Rin} = '0;
        {PCin, IRin, MARin, MDRin, Yin, HIin, LOin} = '0;
        {ZHighIn, ZLowIn, CONin, OutPortin, IncPC, Read, Write} = '0;
        opcode  = 5'b0;
        Address = 9'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Read = 1'b1; MDRin = 1'b1; Mdatain = v;
        tick();
    endtask

    task automatic load_ir(input logic [31:0] v);
        load_mdr(v);
        MDRout = 1'b1; IRin = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        clear = 1'b0;
        Mdatain = 32'h0;
        InPortData = 32'h0;
        #12;
        checks++;
        if (OutPortData !== 32'h0) begin
            errors++;
            $display("FAIL reset_outport: got %h expected %h", OutPortData, 32'h0);
        end
        checks++;
        if (CON_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_con: got %b expected 0", CON_out);
        end
        checks++;
        if (rout !== 16'h0) begin
            errors++;
            $display("FAIL reset_rout: got %h expected %h", rout, 16'h0);
        end
        #3;
        clear = 1'b1;
        PCout = 1'b1; OutPortin = 1'b1;
        tick();
        checks++;
        if (OutPortData !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got %h expected %h", OutPortData, 32'h0);
        end
    endtask

    task automatic test_fetch();
        load_mdr(32'h10);
        MDRout = 1'b1; PCin = 1'b1;
        tick();
        PCout = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; MARin = 1'b1;
        tick();
        checks++;
        if (dut.mar_q !== 32'h10) begin
            errors++;
            $display("FAIL fetch_mar: got %h expected %h", dut.mar_q, 32'h10);
        end
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        OutPortin = 1'b1; Mdatain = 32'h61B00005;
        tick();
        checks++;
        if (OutPortData !== 32'h11) begin
            errors++;
            $display("FAIL fetch_zlo: got %h expected %h", OutPortData, 32'h11);
        end
        PCout = 1'b1; OutPortin = 1'b1;
        tick();
        checks++;
        if (OutPortData !== 32'h11) begin
            errors++;
            $display("FAIL fetch_pc: got %h expected %h", OutPortData, 32'h11);
        end
        MDRout = 1'b1; OutPortin = 1'b1;
        tick();
        checks++;
        if (OutPortData !== 32'h61B00005) begin
            errors++;
            $display("FAIL fetch_mdr: got %h expected %h", OutPortData, 32'h61B00005);
        end
    endtask

    task automatic test_addi();
        MDRout = 1'b1; IRin = 1'b1;
        tick();
        load_mdr(32'd13);
        MDRout = 1'b1; Grb = 1'b1; Rin = 1'b1;
        tick();
        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        #1;
        checks++;
        if (rout !== 16'h0040) begin
            errors++;
            $display("FAIL addi_r6out: got %h expected %h", rout, 16'h0040);
        end
        tick();
        Cout = 1'b1; opcode = 5'b00011; ZLowIn = 1'b1;
        tick();
        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        tick();
        Yout = 1'b1; OutPortin = 1'b1;
        tick();
        checks++;
        if (OutPortData !== 32'd13) begin
            errors++;
            $display("FAIL addi_y: got %h expected %h", OutPortData, 32'd13);
        end
        Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1;
        tick();
        checks++;
        if (OutPortData !== 32'd18) begin
            errors++;
            $display("FAIL addi_r3: got %h expected %h", OutPortData, 32'd18);
        end
        load_ir(32'h00040000);
        Cout = 1'b1; OutPortin = 1'b1;
        tick();
        checks++;
        if (OutPortData !== 32'hFFFC0000) begin
            errors++;
            $display("FAIL cout_sext: got %h expected %h", OutPortData, 32'hFFFC0000);
        end
    endtask

    task automatic test_mul();
        load_mdr(32'hFFFFFFFE);
        MDRout = 1'b1; Yin = 1'b1;
        tick();
        load_mdr(32'd3);
        MDRout = 1'b1; opcode = 5'b10000; ZHighIn = 1'b1; ZLowIn = 1'b1;
        tick();
        Zhighout = 1'b1; HIin = 1'b1;
        tick();
        Zlowout = 1'b1; LOin = 1'b1;
        tick();
        HIout = 1'b1; OutPortin = 1'b1;
        tick();
        checks++;
        if (OutPortData !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL mul_hi: got %h expected %h", OutPortData, 32'hFFFFFFFF);
        end
        LOout = 1'b1; OutPortin = 1'b1;
        tick();
        checks++;
        if (OutPortData !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL mul_lo: got %h expected %h", OutPortData, 32'hFFFFFFFA);
        end
    endtask

    task automatic test_div();
        logic [31:0] av [3];
        logic [31:0] bv [3];
        logic [31:0] qv [3];
        logic [31:0] rv [3];
        av = '{32'd17, 32'hFFFFFFEF, 32'd17};
        bv = '{32'd5,  32'd5,        32'd0};
        qv = '{32'd3,  32'hFFFFFFFD, 32'd0};
        rv = '{32'd2,  32'hFFFFFFFE, 32'd0};
        for (int i = 0; i < 3; i++) begin
            load_mdr(av[i]);
            MDRout = 1'b1; Yin = 1'b1;
            tick();
            load_mdr(bv[i]);
            MDRout = 1'b1; opcode = 5'b01111;
            ZHighIn = 1'b1; ZLowIn = 1'b1;
            tick();
            Zlowout = 1'b1; OutPortin = 1'b1;
            tick();
            checks++;
            if (OutPortData !== qv[i]) begin
                errors++;
                $display("FAIL div_q[%0d]: got %h expected %h", i, OutPortData, qv[i]);
            end
            Zhighout = 1'b1; OutPortin = 1'b1;
            tick();
            checks++;
            if (OutPortData !== rv[i]) begin
                errors++;
                $display("FAIL div_r[%0d]: got %h expected %h", i, OutPortData, rv[i]);
            end
        end
    endtask

    task automatic test_alu();
        logic [4:0]  ops [12];
        logic        inc [12];
        logic [31:0] exp [12];
        ops = '{5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                5'b01010, 5'b01011, 5'b10001, 5'b10010, 5'b00100, 5'b00000};
        inc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        exp = '{32'hF000000B, 32'h00000004, 32'hF000000F, 32'hFF000000,
                32'h000000FF, 32'h0F000000, 32'hFF000000, 32'h000000F0,
                32'hFFFFFFFC, 32'hFFFFFFFB, 32'h00000005, 32'hF0000013};
        load_mdr(32'hF000000F);
        MDRout = 1'b1; Yin = 1'b1;
        tick();
        load_mdr(32'd4);
        for (int i = 0; i < 12; i++) begin
            MDRout = 1'b1; opcode = ops[i]; IncPC = inc[i];
            ZHighIn = 1'b1; ZLowIn = 1'b1;
            tick();
            Zlowout = 1'b1; OutPortin = 1'b1;
            tick();
            checks++;
            if (OutPortData !== exp[i]) begin
                errors++;
                $display("FAIL alu_lo[%0d] op=%b: got %h expected %h",
                         i, ops[i], OutPortData, exp[i]);
            end
            Zhighout = 1'b1; OutPortin = 1'b1;
            tick();
            checks++;
            if (OutPortData !== 32'h0) begin
                errors++;
                $display("FAIL alu_hi[%0d]: got %h expected %h", i, OutPortData, 32'h0);
            end
        end
    endtask

    task automatic test_con();
        logic [31:0] rv [3];
        logic        cv [3];
        rv = '{32'd0, 32'd7, 32'd0};
        cv = '{1'b0, 1'b1, 1'b0};
        load_ir(32'h00280000);
        for (int i = 0; i < 3; i++) begin
            load_mdr(rv[i]);
            MDRout = 1'b1; Grb = 1'b1; Rin = 1'b1;
            tick();
            Grb = 1'b1; Rout = 1'b1; CONin = 1'b1;
            tick();
            checks++;
            if (CON_out !== cv[i]) begin
                errors++;
                $display("FAIL con[%0d]: got %b expected %b", i, CON_out, cv[i]);
            end
        end
        load_ir(32'h00000000);
        load_mdr(32'h1234);
        MDRout = 1'b1; Grb = 1'b1; Rin = 1'b1;
        tick();
        Grb = 1'b1; BAout = 1'b1; OutPortin = 1'b1;
        #1;
        checks++;
        if (rout !== 16'h0001) begin
            errors++;
            $display("FAIL baout_r0out: got %h expected %h", rout, 16'h0001);
        end
        tick();
        checks++;
        if (OutPortData !== 32'h0) begin
            errors++;
            $display("FAIL baout_zero: got %h expected %h", OutPortData, 32'h0);
        end
        Grb = 1'b1; Rout = 1'b1; OutPortin = 1'b1;
        tick();
        checks++;
        if (OutPortData !== 32'h1234) begin
            errors++;
            $display("FAIL rout_r0: got %h expected %h", OutPortData, 32'h1234);
        end
    endtask

    task automatic test_ports_clear();
        InPortData = 32'hA5;
        tick();
        InPortout = 1'b1; OutPortin = 1'b1;
        tick();
        checks++;
        if (OutPortData !== 32'hA5) begin
            errors++;
            $display("FAIL inport_outport: got %h expected %h", OutPortData, 32'hA5);
        end
        load_ir(32'h00280000);
        load_mdr(32'd9);
        MDRout = 1'b1; Grb = 1'b1; Rin = 1'b1;
        tick();
        Grb = 1'b1; Rout = 1'b1; CONin = 1'b1; PCin = 1'b1;
        tick();
        #2;
        clear = 1'b0;
        #1;
        checks++;
        if (OutPortData !== 32'h0) begin
            errors++;
            $display("FAIL clear_outport: got %h expected %h", OutPortData, 32'h0);
        end
        checks++;
        if (CON_out !== 1'b0) begin
            errors++;
            $display("FAIL clear_con: got %b expected 0", CON_out);
        end
        @(negedge clock);
        clear = 1'b1;
        PCout = 1'b1; OutPortin = 1'b1;
        tick();
        checks++;
        if (OutPortData !== 32'h0) begin
            errors++;
            $display("FAIL clear_pc: got %h expected %h", OutPortData, 32'h0);
        end
        Rout = 1'b1; OutPortin = 1'b1;
        tick();
        checks++;
        if (OutPortData !== 32'h0) begin
            errors++;
            $display("FAIL clear_r0: got %h expected %h", OutPortData, 32'h0);
        end
        load_mdr(32'h3C);
        MDRout = 1'b1; OutPortin = 1'b1;
        tick();
        checks++;
        if (OutPortData !== 32'h3C) begin
            errors++;
            $display("FAIL clear_resume: got %h expected %h", OutPortData, 32'h3C);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_addi();
        test_mul();
        test_div();
        test_alu();
        test_con();
        test_ports_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
